// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state enum, opcode/ALUOp/PCSource/ALUSrcB codes, control-word struct and DECODE dispatch for multi_cycle_control_unit
package ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    R_EXEC, R_WB, IMM_EXEC, IMM_WB, BRANCH, JUMP, TRAP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
  } ctrl_t;
  function automatic state_t dispatch(input logic [5:0] op);
    return op inside {OP_LW, OP_SW} ? MEM_ADDR :
           op == OP_RTYPE ? R_EXEC :
           op inside {OP_ADDI, OP_ANDI, OP_ORI} ? IMM_EXEC :
           op inside {OP_BEQ, OP_BNE} ? BRANCH :
           op == OP_J ? JUMP : TRAP;
  endfunction
endpackage

// File: rtl/ctrl_word_decode.sv
// ctrl_word_decode: combinational (state, latched opcode, mem_ready) -> datapath control word
module ctrl_word_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      cw
);
  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_b = SRCB_4;
        cw.ir_write  = mem_ready;
        cw.pc_write  = mem_ready;
      end
      DECODE: cw.alu_src_b = SRCB_IMM_SH;
      MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.iord     = 1'b1;
      end
      MEM_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        cw.mem_write = 1'b1;
        cw.iord      = 1'b1;
      end
      R_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        cw.reg_write = 1'b1;
        cw.reg_dst   = 1'b1;
      end
      IMM_EXEC: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : ALU_ADD;
      end
      IMM_WB: cw.reg_write = 1'b1;
      BRANCH: begin
        cw.alu_src_a        = 1'b1;
        cw.alu_op           = ALU_SUB;
        cw.pc_source        = PC_ALUOUT;
        cw.pc_write_cond    = opcode == OP_BEQ;
        cw.pc_write_cond_ne = opcode == OP_BNE;
      end
      JUMP: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = PC_JUMP;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multi_cycle_control_unit.sv
// multi_cycle_control_unit: multi-cycle MIPS control FSM; in clk/reset/Opcode/mem_ready, out datapath controls, illegal_op/bus_error/instr_done pulses, retired count
module multi_cycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCWriteCondNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             illegal_op,
  output logic             bus_error,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);
  state_t state, state_nx;
  logic [5:0] opc;
  logic [7:0] wcnt;
  logic waiting, timeout;
  ctrl_t cw;
  ctrl_word_decode u_dec (.state(state), .opcode(opc), .mem_ready(mem_ready), .cw(cw));
  assign {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, MemtoReg,
          IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp} = cw;
  assign waiting    = state inside {FETCH, MEM_RD, MEM_WR};
  assign timeout    = waiting && !mem_ready && wcnt == 8'(TIMEOUT_CYCLES);
  assign bus_error  = timeout;
  assign illegal_op = state == TRAP;
  assign instr_done = state inside {MEM_WB, R_WB, IMM_WB, BRANCH, JUMP} || (state == MEM_WR && mem_ready);
  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:    state_nx = mem_ready ? DECODE : FETCH;
      DECODE:   state_nx = dispatch(Opcode);
      MEM_ADDR: state_nx = opc == OP_LW ? MEM_RD : MEM_WR;
      MEM_RD:   state_nx = mem_ready ? MEM_WB : timeout ? FETCH : MEM_RD;
      MEM_WR:   state_nx = mem_ready || timeout ? FETCH : MEM_WR;
      R_EXEC:   state_nx = R_WB;
      IMM_EXEC: state_nx = IMM_WB;
      default:  state_nx = FETCH;
    endcase
  end
  // every exit from a waiting state goes through ready or timeout, so the counter is zero on entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      opc     <= '0;
      wcnt    <= '0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == DECODE) opc <= Opcode;
      wcnt <= waiting && !mem_ready && !timeout ? wcnt + 8'd1 : 8'd0;
      if (instr_done) retired <= retired + 1'b1;
    end
  end
endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// tb_multi_cycle_control_unit: scoreboard bench with a latency/control-word reference model and randomized opcodes and memory waits
module tb_multi_cycle_control_unit;
  localparam int T  = 15;
  localparam int CW = 4;
  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100,
                         BNE = 6'b000101, JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [17:0] PCW = 18'h20000, PCWC = 18'h10000, PCWN = 18'h08000, IORD = 18'h04000,
                          MR = 18'h02000, MW = 18'h01000, M2R = 18'h00800, IRW = 18'h00400,
                          ASA = 18'h00200, RW = 18'h00100, RD = 18'h00080;
  localparam logic [2:0] K_DONE = 3'b100, K_BUS = 3'b010, K_ILL = 3'b001;
  typedef struct {
    logic [2:0]    kind;
    int            len;
    logic [17:0]   cw;
    int            probe;
    logic [17:0]   pcw;
    logic [CW-1:0] ret;
  } exp_t;
  logic clk, reset, mem_ready;
  logic [5:0] Opcode;
  logic PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;
  logic illegal_op, bus_error, instr_done;
  logic [CW-1:0] retired;
  logic [17:0] cur;
  exp_t q[$];
  exp_t me;
  logic [17:0] hist [0:63];
  logic [CW-1:0] exp_ret;
  int total, bad, cyc;
  multi_cycle_control_unit #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_op(illegal_op), .bus_error(bus_error),
    .instr_done(instr_done), .retired(retired)
  );
  assign cur = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask
  function automatic logic [17:0] sel(input int pcs, input int sb, input int op);
    return 18'(pcs * 32 + sb * 8 + op);
  endfunction
  function automatic bit is_valid(input logic [5:0] op);
    return op inside {R_OP, LW, SW, BEQ, BNE, JMP, ADDI, ANDI, ORI};
  endfunction
  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 9));
    return r == 0 ? T : r == 1 ? T + 1 : int'($urandom_range(0, 3));
  endfunction
  // fw/dw: cycles of mem_ready=0 before the fetch / data access completes; more than T means timeout
  task automatic run_txn(input logic [5:0] op, input int fw, input int dw);
    exp_t e;
    int fc, dc, s;
    bit derr, fok, mem;
    fok  = fw <= T;
    derr = dw > T;
    fc   = (fok ? fw : T) + 1;
    dc   = (derr ? T : dw) + 1;
    s    = fc + 3;
    mem  = fok && (op == LW || op == SW);
    e.ret   = exp_ret;
    e.kind  = K_DONE;
    e.probe = fc;
    e.pcw   = MR | IRW | PCW | sel(0, 1, 0);
    e.cw    = '0;
    e.len   = fc + 2;
    if (!fok) begin
      e.len = T + 1; e.kind = K_BUS; e.cw = MR | sel(0, 1, 0); e.probe = 1; e.pcw = e.cw;
    end else begin
      case (op)
        R_OP: begin e.len = fc + 3; e.cw = RW | RD; e.probe = fc + 2; e.pcw = ASA | sel(0, 0, 2); end
        ADDI, ANDI, ORI: begin
          e.len = fc + 3; e.cw = RW; e.probe = fc + 2;
          e.pcw = ASA | sel(0, 2, op == ANDI ? 3 : op == ORI ? 4 : 0);
        end
        BEQ: e.cw = ASA | PCWC | sel(1, 0, 1);
        BNE: e.cw = ASA | PCWN | sel(1, 0, 1);
        JMP: e.cw = PCW | sel(2, 0, 0);
        LW: begin
          e.len = fc + 2 + dc + (derr ? 0 : 1); e.kind = derr ? K_BUS : K_DONE;
          e.cw = derr ? MR | IORD : RW | M2R; e.probe = fc + 2; e.pcw = ASA | sel(0, 2, 0);
        end
        SW: begin
          e.len = fc + 2 + dc; e.kind = derr ? K_BUS : K_DONE;
          e.cw = MW | IORD; e.probe = fc + 2; e.pcw = ASA | sel(0, 2, 0);
        end
        default: e.kind = K_ILL;
      endcase
    end
    if (e.kind == K_DONE) exp_ret = exp_ret + 1'b1;
    q.push_back(e);
    for (int i = 1; i <= e.len; i++) begin
      @(posedge clk);
      #1;
      Opcode = (fok && i == fc + 1) ? op : 6'($urandom);
      mem_ready = i <= fc ? (i == fw + 1) : (mem && i >= s && i < s + dc) ? (i - s == dw) : 1'($urandom);
    end
  endtask
  always @(negedge clk) begin
    if (reset) cyc = -1;
    else begin
      cyc++;
      if (cyc >= 0 && cyc < 64) hist[cyc] = cur;
      if ({instr_done, bus_error, illegal_op} != 3'b000) begin
        if (q.size() == 0) chk("spurious_event", 32'({instr_done, bus_error, illegal_op}), 0);
        else begin
          me = q.pop_front();
          chk("event_kind", 32'({instr_done, bus_error, illegal_op}), 32'(me.kind));
          chk("latency", cyc, me.len);
          chk("event_ctrl", 32'(cur), 32'(me.cw));
          chk("probe_ctrl", 32'(hist[me.probe]), 32'(me.pcw));
          chk("retired", 32'(retired), 32'(me.ret));
        end
        cyc = 0;
      end else if (q.size() > 0 && cyc > q[0].len) begin
        chk("missing_event", cyc, q[0].len);
        q.delete(0);
        cyc = 0;
      end
    end
  end
  initial begin
    logic [5:0] op;
    logic [5:0] ops [0:8];
    ops = '{R_OP, LW, SW, BEQ, BNE, JMP, ADDI, ANDI, ORI};
    total = 0; bad = 0; exp_ret = '0;
    reset = 1'b1; mem_ready = 1'b0; Opcode = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 32'(cur), 0);
    chk("reset_pulses", 32'({instr_done, bus_error, illegal_op}), 0);
    chk("reset_retired", 32'(retired), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_txn(R_OP, 0, 0);
    run_txn(LW, 0, 3);
    run_txn(BNE, 0, 0);
    run_txn(BEQ, 0, 0);
    run_txn(6'b111111, 0, 0);
    run_txn(SW, 0, T + 1);
    run_txn(ANDI, 0, 0);
    run_txn(ORI, 0, 0);
    run_txn(JMP, T, 0);
    run_txn(ADDI, T + 1, 0);
    run_txn(LW, 1, T);
    run_txn(LW, 2, T + 1);
    run_txn(SW, 0, T);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      Opcode = i == 2 ? SW : 6'($urandom);
      mem_ready = i == 1 ? 1'b1 : i == 4 ? 1'b0 : 1'($urandom);
    end
    #2 reset = 1'b1;
    #1;
    chk("midreset_ctrl", 32'(cur), 0);
    chk("midreset_pulses", 32'({instr_done, bus_error, illegal_op}), 0);
    chk("midreset_retired", 32'(retired), 0);
    exp_ret = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom);
        while (is_valid(op)) op = 6'($urandom);
      end else op = ops[$urandom_range(0, 8)];
      run_txn(op, pick(), pick());
    end
    for (int k = 0; k < 100 && q.size() > 0; k++) @(posedge clk);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
